// File: rtl/downlink_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : downlink_scheduler_pkg                                            |
// | Brief  : Shared frame categories, FSM state encoding and byte selector.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package downlink_scheduler_pkg;

  localparam logic [1:0] CTG_START  = 2'b01;
  localparam logic [1:0] CTG_FLAG   = 2'b10;
  localparam logic [1:0] CTG_SCHEME = 2'b11;

  localparam int SCHEME_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_OFFER = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Most-significant byte of the scheme goes out first.
  function automatic logic [7:0] scheme_byte(input logic [47:0] s, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = s[47:40];
      3'd1:    b = s[39:32];
      3'd2:    b = s[31:24];
      3'd3:    b = s[23:16];
      3'd4:    b = s[15:8];
      3'd5:    b = s[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/downlink_scheduler_frame_tracker.sv
// +----------------------------------------------------------------------------+
// | Module : frame_tracker                                                     |
// | Brief  : Detects new demodulator frames, counts skipped ordinals, strobes. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module frame_tracker
  import downlink_scheduler_pkg::*;
#(
  parameter int ORD_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ORD_W-1:0] i_ord,
  input  logic [1:0]       i_ctg,
  output logic             o_flag_stb,
  output logic             o_scheme_stb,
  output logic             o_start_stb,
  output logic [7:0]       o_drop_cnt
);

  localparam int SUM_W = ((ORD_W > 8) ? ORD_W : 8) + 1;

  logic [ORD_W-1:0] r_last_ord;
  logic [7:0]       r_drop_cnt;
  logic [ORD_W-1:0] w_diff;
  logic             w_new_frame;
  logic [SUM_W-1:0] w_sum;

  // Modular difference: a wrap of the ordinal still counts as forward progress.
  assign w_diff      = i_ord - r_last_ord;
  assign w_new_frame = (w_diff != '0);
  assign w_sum       = SUM_W'(r_drop_cnt) + SUM_W'(w_diff) - SUM_W'(1);

  assign o_flag_stb   = w_new_frame && (i_ctg == CTG_FLAG);
  assign o_scheme_stb = w_new_frame && (i_ctg == CTG_SCHEME);
  assign o_start_stb  = w_new_frame && (i_ctg == CTG_START);
  assign o_drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_ord <= '0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_last_ord <= i_ord;
      if (w_diff > ORD_W'(1)) begin
        r_drop_cnt <= (w_sum > SUM_W'(255)) ? 8'hFF : w_sum[7:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/downlink_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module : downlink_scheduler                                                |
// | Brief  : Turns downlink frames into timed codewords for the modulator.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module downlink_scheduler
  import downlink_scheduler_pkg::*;
#(
  parameter logic [15:0] SLOT_LEN = 16'd1000,
  parameter logic [15:0] GAP_LEN  = 16'd500,
  parameter int          ORD_W    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ORD_W-1:0] ord,
  input  logic [1:0]       ctg,
  input  logic [7:0]       cur_flag,
  input  logic [47:0]      cur_scheme,
  input  logic             halt,
  output logic             working,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [7:0]       code,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic             run_done
);

  localparam logic [2:0] c_LAST_IDX = 3'(SCHEME_BYTES - 1);

  logic        w_flag_stb;
  logic        w_scheme_stb;
  logic        w_start_stb;
  logic        w_start_ok;
  logic [3:0]  w_rep_init;
  logic        w_unused;

  state_t      r_state;
  logic [7:0]  r_mode;
  logic [47:0] r_shadow;
  logic        r_scheme_valid;
  logic [47:0] r_active;
  logic [2:0]  r_byte_idx;
  logic [3:0]  r_rep;
  logic [15:0] r_timer;
  logic        r_working;
  logic        r_code_valid;
  logic [7:0]  r_code;
  logic        r_busy;
  logic        r_run_done;

  frame_tracker #(
    .ORD_W (ORD_W)
  ) u_frame_tracker (
    .clk          (clock),
    .rst_n        (reset),
    .i_ord        (ord),
    .i_ctg        (ctg),
    .o_flag_stb   (w_flag_stb),
    .o_scheme_stb (w_scheme_stb),
    .o_start_stb  (w_start_stb),
    .o_drop_cnt   (drop_cnt)
  );

  assign w_start_ok = w_start_stb && r_scheme_valid && r_mode[7] && !halt;
  assign w_rep_init = (r_mode[2:0] == 3'd0) ? 4'd8 : {1'b0, r_mode[2:0]};
  assign w_unused   = ^r_mode[6:3];

  // Shadow copies keep updating during a run; the run itself works from r_active.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mode         <= 8'h00;
      r_shadow       <= 48'h0;
      r_scheme_valid <= 1'b0;
    end else begin
      if (w_flag_stb) r_mode <= cur_flag;
      if (w_scheme_stb) begin
        r_shadow       <= cur_scheme;
        r_scheme_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_active     <= 48'h0;
      r_byte_idx   <= 3'd0;
      r_rep        <= 4'd0;
      r_timer      <= 16'd0;
      r_working    <= 1'b0;
      r_code_valid <= 1'b0;
      r_code       <= 8'h00;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
    end else if (halt && (r_state != ST_IDLE)) begin
      r_state      <= ST_IDLE;
      r_working    <= 1'b0;
      r_code_valid <= 1'b0;
      r_code       <= 8'h00;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state   <= ST_LOAD;
            r_busy    <= 1'b1;
            r_working <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_active     <= r_shadow;
          r_byte_idx   <= 3'd0;
          r_rep        <= w_rep_init;
          r_state      <= ST_OFFER;
          r_code_valid <= 1'b1;
          r_code       <= scheme_byte(r_shadow, 3'd0);
        end
        ST_OFFER: begin
          if (r_code_valid && code_ready) begin
            r_state      <= ST_HOLD;
            r_timer      <= SLOT_LEN - 16'd1;
            r_code_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (r_timer != 16'd0) begin
            r_timer <= r_timer - 16'd1;
          end else if (r_byte_idx < c_LAST_IDX) begin
            r_byte_idx   <= r_byte_idx + 3'd1;
            r_state      <= ST_OFFER;
            r_code_valid <= 1'b1;
            r_code       <= scheme_byte(r_active, r_byte_idx + 3'd1);
          end else if (r_rep > 4'd1) begin
            r_rep   <= r_rep - 4'd1;
            r_timer <= GAP_LEN - 16'd1;
            r_state <= ST_GAP;
            r_code  <= 8'h00;
          end else begin
            r_state    <= ST_DONE;
            r_run_done <= 1'b1;
          end
        end
        ST_GAP: begin
          if (r_timer != 16'd0) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            r_byte_idx   <= 3'd0;
            r_state      <= ST_OFFER;
            r_code_valid <= 1'b1;
            r_code       <= scheme_byte(r_active, 3'd0);
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_working <= 1'b0;
          r_busy    <= 1'b0;
          r_code    <= 8'h00;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign working    = r_working;
  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign busy       = r_busy;
  assign run_done   = r_run_done;

endmodule

`default_nettype wire

// File: doc/downlink_scheduler.md
Name: downlink_scheduler

Overview:
- Consumes the decoded downlink frames from the envelope demodulator: frame ordinal `ord`, category `ctg`, 8-bit flag and 48-bit scheme.
- Turns them into a timed sequence of 8-bit codewords for the backscatter modulator.
- Owns the demodulator's `working` input, so the receiver is held clear while the tag is transmitting.
- Sits between the demodulator and the modulator codeword interface.

Parameters:
- SLOT_LEN, 16'd1000, clock cycles each codeword is held after acceptance.
- GAP_LEN, 16'd500, idle cycles between repetitions of the 6-codeword scheme.
- ORD_W, 2, width of the demodulator frame ordinal.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-low reset
- ord  in  ORD_W  frame ordinal from demodulator; increments once per valid frame
- ctg  in  2  category of the latest frame: 01 start, 10 flag, 11 scheme
- cur_flag  in  8  flag payload
- cur_scheme  in  48  scheme payload
- halt  in  1  host abort, level-sensitive
- working  out  1  to demodulator; high while a transmission is running
- code_valid  out  1  codeword offered to modulator
- code_ready  in  1  modulator accepts codeword
- code  out  8  current codeword
- busy  out  1  state is not IDLE
- drop_cnt  out  8  count of frames lost (ordinal skipped), saturating
- run_done  out  1  one-cycle pulse when a run completes normally

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-low.
  - With reset low at a clock edge, all registers clear.
  - working, code_valid, busy and run_done reset to 0; code and drop_cnt reset to 0.
  - last_ord, mode and shadow scheme reset to 0; scheme_valid resets to 0; state resets to IDLE.
  - Reset mid-run aborts immediately with no further codewords.
- Frame detect:
  - new_frame = (ord != last_ord), evaluated every cycle; last_ord <= ord every cycle.
  - If (ord - last_ord) mod 2^ORD_W > 1, drop_cnt increments by the difference minus 1, saturating at 255.
  - Frame handling is valid in every state, but is effectively idle in RUN/GAP because working suppresses decoding.
- Frame actions on new_frame:
  - ctg=10: mode <= cur_flag. mode[7] is the enable; mode[2:0] is the repeat count, where 0 means 8.
  - ctg=11: shadow <= cur_scheme and scheme_valid <= 1. During RUN/GAP the shadow update still happens, but the active run keeps its own latched copy.
  - ctg=01: start request, honoured only in IDLE with scheme_valid=1 and mode[7]=1; otherwise ignored.
  - ctg=00: ignored.
- State machine: IDLE, LOAD, OFFER, HOLD, GAP, DONE.
  - IDLE -> LOAD on an accepted start.
  - LOAD, 1 cycle: active <= shadow; byte_idx <= 0; rep <= mode[2:0] (0 maps to 8); working <= 1.
  - OFFER: code_valid=1 with code = active[47-8*byte_idx -: 8] (MSB byte first). On code_valid & code_ready, go to HOLD; timer <= SLOT_LEN-1; code_valid deasserts next cycle.
  - OFFER holds code stable while ready is low, with no timeout.
  - HOLD: code stays driven. When timer = 0:
    - if byte_idx < 5: byte_idx++ and go to OFFER;
    - else if rep > 1: rep--; timer <= GAP_LEN-1; go to GAP;
    - else go to DONE.
  - GAP: code = 0. When timer = 0: byte_idx <= 0 and go to OFFER.
  - DONE, 1 cycle: run_done = 1; working <= 0; go to IDLE. scheme_valid is retained, so a fresh start replays the same scheme.
- halt:
  - In any non-IDLE state, halt=1 goes to IDLE next cycle, drops code_valid and working, and gives no run_done.
  - In IDLE, halt blocks starts.
- Widths: timer 16 bits; byte_idx 3 bits; rep 4 bits. The drop_cnt difference uses ORD_W-bit modular subtraction.
- Simultaneous events:
  - halt has priority over handshake completion.
  - Start and scheme frames cannot coincide, since ord advances at most once per 50 cycles.

Decomposition:
- Shared package holds:
  - category constants CTG_START=2'b01, CTG_FLAG=2'b10, CTG_SCHEME=2'b11;
  - the state enum;
  - SCHEME_BYTES=6.
- One sub-module, `frame_tracker`, containing last_ord, new_frame, drop_cnt saturation and frame-action strobes. The FSM stays in the top level.

Test Plan:
- Flag 8'h82 then scheme 48'h0102_0304_0506 then start, with ready tied high and SLOT_LEN=4, GAP_LEN=2:
  - codes 01..06 are each accepted once;
  - gap, then 01..06 repeat;
  - run_done pulses once;
  - working is high from LOAD to DONE.
- Start without a prior scheme, or with mode[7]=0 -> stays IDLE, busy=0, no code_valid.
- ready held low 20 cycles during OFFER of byte 3:
  - code stays 8'h03 with code_valid high;
  - after ready, HOLD lasts exactly SLOT_LEN cycles.
- halt asserted in HOLD of byte 2 -> next cycle IDLE, working=0, code_valid=0, no run_done. A subsequent start replays from byte 01.
- ord jumps 0->2, then 2->1 -> drop_cnt = 1, then 3. Force 300 skips -> drop_cnt saturates at 255.
- Scheme frame forced during RUN:
  - current run finishes with the old bytes;
  - the next start emits the new scheme.
- Synchronous reset asserted mid-OFFER -> all outputs 0 on the following edge.
